ball_counter: RTL and testbench
===============================

# ball_counter

Front-end stage of the cricket scoring path: turns the raw delivery push-button into a clean one-cycle `delivery` strobe and keeps per-team legal-ball counts. Wides and no-balls do not count as legal balls. It feeds `delivery`, `team1Balls`, `team2Balls` and `balls` directly to the scoring and comparator stages. It samples the same LFSR value those stages use, so extras are classified identically everywhere.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a press or a release.
- `MAX_BALLS`, default 120: innings ball limit; counts saturate here.
- Reset is one clock domain, asynchronous and active-high; all flops clear on `posedge reset`.
- `clk_fpga`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `delivery_btn`  in  1  raw, bouncy push-button; asynchronous to `clk_fpga`.
- `teamSwitch`  in  1  0 = team 1 batting, 1 = team 2 batting.
- `lfsr_out`  in  4  current random outcome code.
- `binaryWickets`  in  4  wickets of the batting team.
- `gameOver`  in  1  freezes all counting.
- `delivery`  out  1  one-cycle strobe per accepted press.
- `team1Balls`  out  7  legal balls bowled to team 1.
- `team2Balls`  out  7  legal balls bowled to team 2.
- `balls`  out  16  legal balls of the batting team, zero-extended.
- `overs`  out  5  completed overs of the batting team (only with `BALL_COUNTER_OVERS_EN`).
- `ballInOver`  out  3  balls into the current over, 0..5 (only with `BALL_COUNTER_OVERS_EN`).

## Operation
- `delivery_btn` passes through a 2-flop synchroniser before the debounce FSM.
- Debounce FSM states:
  - IDLE: waiting for the synchronised level to go high.
  - PRESS_CHK: counts consecutive high cycles; any low returns to IDLE and clears the count.
  - FIRE: one cycle; requests the strobe.
  - RELEASE_CHK: counts consecutive low cycles; any high clears the count. Reaching `DEBOUNCE_CYCLES` returns to IDLE.
- Innings live means all of: `!gameOver`, `binaryWickets < 10`, and the batting team's count `< MAX_BALLS`.
- The strobe from FIRE drives `delivery` only if the innings is live. Otherwise it is dropped silently; the FSM still proceeds to RELEASE_CHK.
- In a `delivery` cycle, `lfsr_out` is sampled in that same cycle:
  - 13 (wide) or 14 (no-ball): no count change.
  - Any other code: the batting team's count increments by 1.
- Counts saturate at `MAX_BALLS` and never wrap.
- `balls` = zero-extended `team1Balls` when `teamSwitch` = 0, `team2Balls` otherwise.
- Toggling `teamSwitch` never modifies either stored count.

## Timing
- Reset values: all outputs 0, FSM in IDLE, synchroniser and debounce counter 0.
- Press latency: `delivery` goes high exactly `2 + DEBOUNCE_CYCLES + 1` rising edges after the first edge that samples `delivery_btn` high, provided the input stays high throughout.
- `delivery` is high for exactly one cycle. At most one strobe is produced per press/release pair.
- Team counts are registered: they update on the edge ending the `delivery` cycle.
- `balls` (and `overs`/`ballInOver`) are registered: they reflect the new count one cycle after the team count updates.
- `teamSwitch` toggle: `balls` shows the other team's count one cycle later.
- Simultaneous strobe and `gameOver` rising in the same cycle: `delivery` is suppressed and nothing is counted.
- Reset asserted mid-debounce or mid-innings: immediate return to reset values; no strobe is emitted after reset deasserts unless a fresh full press is detected.

## Configuration
- `BALL_COUNTER_OVERS_EN` defined:
  - Ports `overs` and `ballInOver` exist.
  - They are maintained as registered incremental counters tracking the batting team (per-team shadow pairs). No divider is used.
  - `ballInOver` wraps 5 → 0 with `overs` += 1.
  - At `MAX_BALLS` the outputs read `overs` = 20, `ballInOver` = 0.
- Undefined: neither the ports nor the logic exist; everything else is unchanged.

## Structure
- Shared package `cricket_pkg` holds:
  - `MAX_BALLS_DEF` = 120, `BALLS_PER_OVER` = 6, `WICKET_LIMIT` = 10.
  - Outcome codes `OUT_WIDE` = 13, `OUT_NOBALL` = 14.
  - The debounce FSM state enum.
- One sub-module, `button_debounce`: synchroniser, debounce FSM and counter. It outputs a raw one-cycle `press` pulse.
- `ball_counter` adds the innings-live gating and all counting.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Clean press held 20 cycles, `lfsr_out` = 5 → exactly one `delivery` pulse 7 edges after the first high sample; `team1Balls` = 1; `balls` = 1 one cycle later.
- Bouncy press (high 2, low 1, high 10 cycles) → exactly one pulse, timed from the final high run; a second bounce burst on release produces no pulse.
- Presses with `lfsr_out` = 13, then 14, then 15 → three pulses; `team1Balls` = 1 at the end (only the code-15 wicket ball counts).
- 120 legal presses for team 1, then a 121st → `team1Balls` stays 120 and the 121st press emits no `delivery`. With `BALL_COUNTER_OVERS_EN`: `overs` = 20, `ballInOver` = 0; after 7 balls the outputs read `overs` = 1, `ballInOver` = 1.
- 3 balls for team 1, set `teamSwitch` = 1, 2 balls → `team1Balls` = 3, `team2Balls` = 2, `balls` = 2. Toggling `teamSwitch` back makes `balls` = 3 the next cycle.
- Reset asserted during PRESS_CHK with `team2Balls` = 9 → all outputs 0 immediately; no pulse after release of reset until a full new press.

Source files
------------

// File: rtl/cricket_pkg.sv
// Shared constants, outcome codes and the debounce state type for the cricket scoring path.
package cricket_pkg;

    localparam int MAX_BALLS_DEF  = 120;
    localparam int BALLS_PER_OVER = 6;
    localparam int WICKET_LIMIT   = 10;

    localparam int OUT_WIDE   = 13;
    localparam int OUT_NOBALL = 14;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        FIRE,
        RELEASE_CHK
    } debounce_state_t;

    // Wides and no-balls are deliveries that do not count as legal balls.
    function automatic logic is_extra(input logic [3:0] code);
        return (code == 4'(OUT_WIDE)) || (code == 4'(OUT_NOBALL));
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus press/release debounce FSM; emits a raw one-cycle press pulse.
module button_debounce
    import cricket_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_fpga,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(DEBOUNCE_CYCLES);

    logic            sync_meta;
    logic            sync_level;
    debounce_state_t state;
    debounce_state_t state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;

    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
        end else begin
            sync_meta  <= btn;
            sync_level <= sync_meta;
        end
    end

    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Both check states need an unbroken run; any opposite sample restarts the count.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (sync_level) begin
                    state_next = PRESS_CHK;
                end
            end
            PRESS_CHK: begin
                if (!sync_level) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LIMIT) begin
                    state_next = FIRE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            FIRE: begin
                state_next = RELEASE_CHK;
                cnt_next   = '0;
            end
            RELEASE_CHK: begin
                if (sync_level) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LIMIT) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign press = (state == FIRE);

endmodule

// File: rtl/ball_counter.sv
// Delivery strobe generation and per-team legal-ball counting.
// Optional overs/ballInOver outputs are built when BALL_COUNTER_OVERS_EN is defined.
module ball_counter
    import cricket_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_BALLS       = MAX_BALLS_DEF
) (
    input  logic        clk_fpga,
    input  logic        reset,
    input  logic        delivery_btn,
    input  logic        teamSwitch,
    input  logic [3:0]  lfsr_out,
    input  logic [3:0]  binaryWickets,
    input  logic        gameOver,
    output logic        delivery,
    output logic [6:0]  team1Balls,
    output logic [6:0]  team2Balls,
    output logic [15:0] balls
`ifdef BALL_COUNTER_OVERS_EN
    ,
    output logic [4:0]  overs,
    output logic [2:0]  ballInOver
`endif
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_BALLS);

    logic       press;
    logic [6:0] bat_count;
    logic       live;
    logic       count_ball;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_fpga(clk_fpga),
        .reset   (reset),
        .btn     (delivery_btn),
        .press   (press)
    );

    // Gating is combinational so a gameOver arriving with the strobe still suppresses it.
    assign bat_count  = teamSwitch ? team2Balls : team1Balls;
    assign live       = !gameOver && (binaryWickets < 4'(WICKET_LIMIT)) && (bat_count < MAX_CNT);
    assign delivery   = press && live;
    assign count_ball = delivery && !is_extra(lfsr_out);

    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            team1Balls <= '0;
            team2Balls <= '0;
        end else if (count_ball) begin
            if (teamSwitch) begin
                if (team2Balls < MAX_CNT) team2Balls <= team2Balls + 1'b1;
            end else begin
                if (team1Balls < MAX_CNT) team1Balls <= team1Balls + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            balls <= '0;
        end else begin
            balls <= {9'd0, bat_count};
        end
    end

`ifdef BALL_COUNTER_OVERS_EN
    localparam logic [2:0] BIO_LAST = 3'(BALLS_PER_OVER - 1);

    logic [4:0] team1_overs;
    logic [2:0] team1_bio;
    logic [4:0] team2_overs;
    logic [2:0] team2_bio;

    // Shadow pairs advance alongside the ball counts, so no divider is needed.
    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            team1_overs <= '0;
            team1_bio   <= '0;
            team2_overs <= '0;
            team2_bio   <= '0;
        end else if (count_ball) begin
            if (teamSwitch) begin
                if (team2Balls < MAX_CNT) begin
                    if (team2_bio == BIO_LAST) begin
                        team2_bio   <= '0;
                        team2_overs <= team2_overs + 1'b1;
                    end else begin
                        team2_bio <= team2_bio + 1'b1;
                    end
                end
            end else begin
                if (team1Balls < MAX_CNT) begin
                    if (team1_bio == BIO_LAST) begin
                        team1_bio   <= '0;
                        team1_overs <= team1_overs + 1'b1;
                    end else begin
                        team1_bio <= team1_bio + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            overs      <= '0;
            ballInOver <= '0;
        end else begin
            overs      <= teamSwitch ? team2_overs : team1_overs;
            ballInOver <= teamSwitch ? team2_bio   : team1_bio;
        end
    end
`endif

endmodule

// File: tb/tb_ball_counter.sv
// Directed self-checking bench for ball_counter with DEBOUNCE_CYCLES = 4.
module tb_ball_counter;

    logic        clk_fpga = 1'b0;
    logic        reset = 1'b1;
    logic        delivery_btn = 1'b0;
    logic        teamSwitch = 1'b0;
    logic [3:0]  lfsr_out = 4'd5;
    logic [3:0]  binaryWickets = 4'd0;
    logic        gameOver = 1'b0;
    logic        delivery;
    logic [6:0]  team1Balls;
    logic [6:0]  team2Balls;
    logic [15:0] balls;
`ifdef BALL_COUNTER_OVERS_EN
    logic [4:0]  overs;
    logic [2:0]  ballInOver;
`endif

    int nChecks = 0;
    int nFail = 0;

    ball_counter #(
        .DEBOUNCE_CYCLES(4),
        .MAX_BALLS(120)
    ) dut (
        .clk_fpga     (clk_fpga),
        .reset        (reset),
        .delivery_btn (delivery_btn),
        .teamSwitch   (teamSwitch),
        .lfsr_out     (lfsr_out),
        .binaryWickets(binaryWickets),
        .gameOver     (gameOver),
        .delivery     (delivery),
        .team1Balls   (team1Balls),
        .team2Balls   (team2Balls),
        .balls        (balls)
`ifdef BALL_COUNTER_OVERS_EN
        ,
        .overs        (overs),
        .ballInOver   (ballInOver)
`endif
    );

    always #5 clk_fpga = ~clk_fpga;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk_fpga);
        @(posedge clk_fpga);
        #1;
        reset = 1'b0;
    endtask

    // Holds the button high for 'hold' edges then low for 'rel' edges, counting strobes.
    task automatic do_press(input int hold, input int rel, output int pulses, output int first);
        pulses = 0;
        first = -1;
        delivery_btn = 1'b1;
        for (int i = 0; i < hold + rel; i++) begin
            if (i == hold) delivery_btn = 1'b0;
            @(posedge clk_fpga);
            #1;
            if (delivery) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        delivery_btn = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        nChecks++;
        if ({delivery, team1Balls, team2Balls, balls} !== 31'd0) begin
            nFail++;
            $display("[TB] FAIL reset_outputs: got %0h expected 0", {delivery, team1Balls, team2Balls, balls});
        end
        apply_reset();
        @(posedge clk_fpga);
        #1;
        nChecks++;
        if ({delivery, team1Balls, team2Balls, balls} !== 31'd0) begin
            nFail++;
            $display("[TB] FAIL post_reset_outputs: got %0h expected 0", {delivery, team1Balls, team2Balls, balls});
        end
`ifdef BALL_COUNTER_OVERS_EN
        nChecks++;
        if (overs !== 5'd0 || ballInOver !== 3'd0) begin
            nFail++;
            $display("[TB] FAIL reset_overs: got %0d.%0d expected 0.0", overs, ballInOver);
        end
`endif
    endtask

    task automatic test_clean_press();
        int pulses;
        int first;
        pulses = 0;
        first = -1;
        lfsr_out = 4'd5;
        delivery_btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) delivery_btn = 1'b0;
            @(posedge clk_fpga);
            #1;
            if (delivery) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (i == 8) begin
                nChecks++;
                if (team1Balls !== 7'd1 || balls !== 16'd0) begin
                    nFail++;
                    $display("[TB] FAIL clean_count_edge: team1Balls=%0d balls=%0d expected 1 and 0", team1Balls, balls);
                end
            end
            if (i == 9) begin
                nChecks++;
                if (balls !== 16'd1) begin
                    nFail++;
                    $display("[TB] FAIL clean_balls_edge: got %0d expected 1", balls);
                end
            end
        end
        nChecks++;
        if (pulses !== 1) begin
            nFail++;
            $display("[TB] FAIL clean_pulses: got %0d expected 1", pulses);
        end
        nChecks++;
        if (first !== 7) begin
            nFail++;
            $display("[TB] FAIL clean_latency: got %0d expected 7", first);
        end
    endtask

    task automatic test_bouncy_press();
        logic [25:0] pattern;
        int pulses;
        int first;
        pattern = 26'b11_0_1111111111_00_1_0000000000;
        pulses = 0;
        first = -1;
        for (int i = 0; i < 26; i++) begin
            delivery_btn = pattern[25 - i];
            @(posedge clk_fpga);
            #1;
            if (delivery) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        delivery_btn = 1'b0;
        repeat (4) @(posedge clk_fpga);
        #1;
        nChecks++;
        if (pulses !== 1) begin
            nFail++;
            $display("[TB] FAIL bouncy_pulses: got %0d expected 1", pulses);
        end
        nChecks++;
        if (first !== 10) begin
            nFail++;
            $display("[TB] FAIL bouncy_latency: got %0d expected 10", first);
        end
        nChecks++;
        if (team1Balls !== 7'd2 || balls !== 16'd2) begin
            nFail++;
            $display("[TB] FAIL bouncy_count: team1Balls=%0d balls=%0d expected 2", team1Balls, balls);
        end
    endtask

    task automatic test_extras();
        int pulses;
        int first;
        int total;
        apply_reset();
        total = 0;
        lfsr_out = 4'd13;
        do_press(8, 10, pulses, first);
        total += pulses;
        nChecks++;
        if (team1Balls !== 7'd0) begin
            nFail++;
            $display("[TB] FAIL wide_not_counted: got %0d expected 0", team1Balls);
        end
        lfsr_out = 4'd14;
        do_press(8, 10, pulses, first);
        total += pulses;
        lfsr_out = 4'd15;
        do_press(8, 10, pulses, first);
        total += pulses;
        nChecks++;
        if (total !== 3) begin
            nFail++;
            $display("[TB] FAIL extras_pulses: got %0d expected 3", total);
        end
        nChecks++;
        if (team1Balls !== 7'd1 || balls !== 16'd1) begin
            nFail++;
            $display("[TB] FAIL extras_count: team1Balls=%0d balls=%0d expected 1", team1Balls, balls);
        end
        lfsr_out = 4'd5;
    endtask

    task automatic test_gating();
        int pulses;
        int first;
        apply_reset();
        gameOver = 1'b1;
        do_press(8, 10, pulses, first);
        nChecks++;
        if (pulses !== 0 || team1Balls !== 7'd0) begin
            nFail++;
            $display("[TB] FAIL gameover_gate: pulses=%0d team1Balls=%0d expected 0 and 0", pulses, team1Balls);
        end
        gameOver = 1'b0;
        binaryWickets = 4'd10;
        do_press(8, 10, pulses, first);
        nChecks++;
        if (pulses !== 0 || team1Balls !== 7'd0) begin
            nFail++;
            $display("[TB] FAIL wicket_gate: pulses=%0d team1Balls=%0d expected 0 and 0", pulses, team1Balls);
        end
        binaryWickets = 4'd9;
        do_press(8, 10, pulses, first);
        nChecks++;
        if (pulses !== 1 || team1Balls !== 7'd1) begin
            nFail++;
            $display("[TB] FAIL nine_wickets_live: pulses=%0d team1Balls=%0d expected 1 and 1", pulses, team1Balls);
        end
        pulses = 0;
        delivery_btn = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i == 8) delivery_btn = 1'b0;
            @(posedge clk_fpga);
            #1;
            if (i == 6) gameOver = 1'b1;
            if (i == 7) begin
                nChecks++;
                if (delivery !== 1'b0) begin
                    nFail++;
                    $display("[TB] FAIL gameover_same_cycle: delivery=%0d expected 0", delivery);
                end
            end
        end
        nChecks++;
        if (team1Balls !== 7'd1) begin
            nFail++;
            $display("[TB] FAIL gameover_same_cycle_count: got %0d expected 1", team1Balls);
        end
        gameOver = 1'b0;
        binaryWickets = 4'd0;
    endtask

    task automatic test_saturation();
        int pulses;
        int first;
        apply_reset();
        lfsr_out = 4'd5;
        for (int b = 1; b <= 120; b++) begin
            do_press(8, 10, pulses, first);
            nChecks++;
            if (pulses !== 1) begin
                nFail++;
                $display("[TB] FAIL sat_press_%0d: pulses=%0d expected 1", b, pulses);
            end
`ifdef BALL_COUNTER_OVERS_EN
            if (b == 7) begin
                nChecks++;
                if (overs !== 5'd1 || ballInOver !== 3'd1) begin
                    nFail++;
                    $display("[TB] FAIL overs_after_7: got %0d.%0d expected 1.1", overs, ballInOver);
                end
            end
`endif
        end
        nChecks++;
        if (team1Balls !== 7'd120 || balls !== 16'd120) begin
            nFail++;
            $display("[TB] FAIL sat_120: team1Balls=%0d balls=%0d expected 120", team1Balls, balls);
        end
`ifdef BALL_COUNTER_OVERS_EN
        nChecks++;
        if (overs !== 5'd20 || ballInOver !== 3'd0) begin
            nFail++;
            $display("[TB] FAIL overs_at_max: got %0d.%0d expected 20.0", overs, ballInOver);
        end
`endif
        do_press(8, 10, pulses, first);
        nChecks++;
        if (pulses !== 0) begin
            nFail++;
            $display("[TB] FAIL sat_121_pulse: got %0d expected 0", pulses);
        end
        nChecks++;
        if (team1Balls !== 7'd120) begin
            nFail++;
            $display("[TB] FAIL sat_121_count: got %0d expected 120", team1Balls);
        end
    endtask

    task automatic test_team_switch();
        int pulses;
        int first;
        apply_reset();
        lfsr_out = 4'd2;
        repeat (3) do_press(8, 10, pulses, first);
        teamSwitch = 1'b1;
        repeat (2) do_press(8, 10, pulses, first);
        nChecks++;
        if (team1Balls !== 7'd3 || team2Balls !== 7'd2 || balls !== 16'd2) begin
            nFail++;
            $display("[TB] FAIL switch_counts: t1=%0d t2=%0d balls=%0d expected 3 2 2", team1Balls, team2Balls, balls);
        end
        teamSwitch = 1'b0;
        #1;
        nChecks++;
        if (balls !== 16'd2) begin
            nFail++;
            $display("[TB] FAIL switch_before_edge: got %0d expected 2", balls);
        end
        @(posedge clk_fpga);
        #1;
        nChecks++;
        if (balls !== 16'd3 || team2Balls !== 7'd2) begin
            nFail++;
            $display("[TB] FAIL switch_back: balls=%0d t2=%0d expected 3 and 2", balls, team2Balls);
        end
        lfsr_out = 4'd5;
    endtask

    task automatic test_reset_mid();
        int pulses;
        int first;
        apply_reset();
        teamSwitch = 1'b1;
        repeat (9) do_press(8, 10, pulses, first);
        nChecks++;
        if (team2Balls !== 7'd9) begin
            nFail++;
            $display("[TB] FAIL mid_setup: got %0d expected 9", team2Balls);
        end
        delivery_btn = 1'b1;
        repeat (4) @(posedge clk_fpga);
        #2;
        reset = 1'b1;
        #1;
        nChecks++;
        if ({delivery, team1Balls, team2Balls, balls} !== 31'd0) begin
            nFail++;
            $display("[TB] FAIL mid_reset_outputs: got %0h expected 0", {delivery, team1Balls, team2Balls, balls});
        end
        delivery_btn = 1'b0;
        repeat (3) @(posedge clk_fpga);
        #1;
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_fpga);
            #1;
            if (delivery) pulses++;
        end
        nChecks++;
        if (pulses !== 0) begin
            nFail++;
            $display("[TB] FAIL mid_no_spurious: got %0d expected 0", pulses);
        end
        do_press(8, 10, pulses, first);
        nChecks++;
        if (pulses !== 1 || team2Balls !== 7'd1 || balls !== 16'd1) begin
            nFail++;
            $display("[TB] FAIL mid_fresh_press: pulses=%0d t2=%0d balls=%0d expected 1 1 1", pulses, team2Balls, balls);
        end
        teamSwitch = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_clean_press();
        test_bouncy_press();
        test_extras();
        test_gating();
        test_saturation();
        test_team_switch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
